// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the SPART receive path: frame defaults, the
// oversample tick constants and the receive FSM state encoding.
// -----------------------------------------------------------------------------
package spart_pkg;

  // Default frame geometry.
  localparam int SPART_DATA_BITS = 8;
  localparam int SPART_OSR       = 16;

  // Tick positions within one bit period for the default OSR.
  localparam int MID_TICK  = SPART_OSR / 2 - 1;  // mid start bit
  localparam int LAST_TICK = SPART_OSR - 1;      // mid data/stop bit

  // Receive FSM, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } rx_state_e;

  // Same tick positions for a non-default OSR.
  function automatic int mid_tick(input int osr);
    return osr / 2 - 1;
  endfunction

  function automatic int last_tick(input int osr);
    return osr - 1;
  endfunction

endpackage

// File: rtl/spart_rx_tick_cnt.sv
// -----------------------------------------------------------------------------
// spart_rx_tick_cnt
// Oversample tick counter and received-bit counter for the rx framer.
//
// Ports:
//   clk, rst_n    clock / async active-low reset
//   i_en          oversample enable (brg_en); counters only move when high
//   i_tick_clr    clear the tick counter (priority over i_tick_run)
//   i_tick_run    advance the tick counter (wraps modulo OSR)
//   i_bit_clr     clear the bit counter (priority over i_bit_inc)
//   i_bit_inc     advance the bit counter
//   o_tick_mid    tick counter at OSR/2-1
//   o_tick_last   tick counter at OSR-1
//   o_bit_last    bit counter at DATA_BITS-1
// -----------------------------------------------------------------------------
module spart_rx_tick_cnt
  import spart_pkg::*;
#(
  parameter int DATA_BITS = SPART_DATA_BITS,
  parameter int OSR       = SPART_OSR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_tick_clr,
  input  logic i_tick_run,
  input  logic i_bit_clr,
  input  logic i_bit_inc,
  output logic o_tick_mid,
  output logic o_tick_last,
  output logic o_bit_last
);

  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_BITS) + 1;

  logic [TW-1:0] r_tick;
  logic [BW-1:0] r_bit;

  // OSR is a power of two, so the natural wrap of r_tick is the bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_bit  <= '0;
    end else if (i_en) begin
      if (i_tick_clr)      r_tick <= '0;
      else if (i_tick_run) r_tick <= r_tick + 1'b1;

      if (i_bit_clr)       r_bit <= '0;
      else if (i_bit_inc)  r_bit <= r_bit + 1'b1;
    end
  end

  assign o_tick_mid  = (r_tick == TW'(mid_tick(OSR)));
  assign o_tick_last = (r_tick == TW'(last_tick(OSR)));
  assign o_bit_last  = (r_bit  == BW'(DATA_BITS - 1));

endmodule

// File: rtl/spart_rx_frame.sv
// -----------------------------------------------------------------------------
// spart_rx_frame
// SPART receive framer. Validates the start bit at its midpoint, samples
// DATA_BITS data bits LSB-first at mid-bit, checks the stop bit and hands the
// byte to the bus interface with data-available / framing / overrun flags.
//
// Ports:
//   clk, rst_n    clock / async active-low reset
//   brg_en        one-clk oversample tick, OSR per bit period
//   rx_sample     synchronized serial line (idle high)
//   rd_ack        one-clk pulse: byte consumed (honoured on any clk)
//   rx_data       last accepted byte
//   rda           receive data available
//   frame_err     stop bit of the accepted byte was 0
//   overrun       a byte completed while rda=1 and was discarded
//   busy          FSM not idle
// -----------------------------------------------------------------------------
module spart_rx_frame
  import spart_pkg::*;
#(
  parameter int DATA_BITS = SPART_DATA_BITS,
  parameter int OSR       = SPART_OSR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 brg_en,
  input  logic                 rx_sample,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  rx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rda, r_frame_err, r_overrun;

  logic w_tick_clr, w_tick_run, w_bit_clr, w_bit_inc;
  logic w_tick_mid, w_tick_last, w_bit_last;
  logic w_sample_bit, w_commit;

  spart_rx_tick_cnt #(
    .DATA_BITS (DATA_BITS),
    .OSR       (OSR)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (brg_en),
    .i_tick_clr  (w_tick_clr),
    .i_tick_run  (w_tick_run),
    .i_bit_clr   (w_bit_clr),
    .i_bit_inc   (w_bit_inc),
    .o_tick_mid  (w_tick_mid),
    .o_tick_last (w_tick_last),
    .o_bit_last  (w_bit_last)
  );

  // Everything here is qualified by brg_en; without it the FSM holds.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_clr   = 1'b0;
    w_tick_run   = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_sample_bit = 1'b0;
    w_commit     = 1'b0;
    if (brg_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!rx_sample) begin
            w_state_nxt = ST_START;
            w_tick_clr  = 1'b1;
          end
        end
        ST_START: begin
          if (w_tick_mid) begin
            // Line must still be low at mid start bit, else it was a glitch.
            if (!rx_sample) begin
              w_state_nxt = ST_DATA;
              w_tick_clr  = 1'b1;
              w_bit_clr   = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_tick_run = 1'b1;
          end
        end
        ST_DATA: begin
          // Tick counter wraps to 0 on the sample tick, re-aligning to mid-bit.
          w_tick_run = 1'b1;
          if (w_tick_last) begin
            w_sample_bit = 1'b1;
            w_bit_inc    = 1'b1;
            if (w_bit_last) w_state_nxt = ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick_last) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_tick_run = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      // LSB arrives first, so shift right and insert at the MSB.
      if (w_sample_bit) r_shift <= {rx_sample, r_shift[DATA_BITS-1:1]};
    end
  end

  // Commit has priority over rd_ack: an ack on the commit cycle frees the
  // holding register, so the new byte loads instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= '0;
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_commit) begin
      if (!r_rda || rd_ack) begin
        r_rx_data   <= r_shift;
        r_rda       <= 1'b1;
        r_frame_err <= ~rx_sample;
        r_overrun   <= 1'b0;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (rd_ack) begin
      r_rda       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rda       = r_rda;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_spart_rx_frame
// Frame-level bench: the driver knows each frame it puts on the line, so the
// expected outputs follow from frame arithmetic (start detected on tick 0,
// start validated on tick 8, commit on tick 152 = 8 + 9*16) and the flag rules.
// A compare process checks all outputs against that model every clock.
// -----------------------------------------------------------------------------
module tb_spart_rx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       brg_en = 1'b0;
  logic       rx_sample = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rda, frame_err, overrun, busy;

  spart_rx_frame dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .brg_en    (brg_en),
    .rx_sample (rx_sample),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam int EV_NONE = 0, EV_START = 1, EV_COMMIT = 2, EV_ABORT = 3;
  localparam int COMMIT_IDX = 152;

  int tests = 0;
  int fails = 0;

  // Model state.
  logic [7:0] e_data = 8'h00;
  logic       e_rda = 1'b0, e_fe = 1'b0, e_ovr = 1'b0, e_busy = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  int         gt = 0;           // global brg tick index
  int         pend_abort = -1;  // tick where a pending false start aborts
  int         ack_pm = 0;       // random rd_ack rate per clk, per mille
  bit         chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      check("rx_data",   32'(rx_data),   32'(e_data));
      check("rda",       32'(rda),       32'(e_rda));
      check("frame_err", 32'(frame_err), 32'(e_fe));
      check("overrun",   32'(overrun),   32'(e_ovr));
      check("busy",      32'(busy),      32'(e_busy));
    end
  end

  // One clock: drive inputs at negedge, apply the model after the posedge.
  task automatic cyc(input logic en, input logic lv, input logic ack, input int evt,
                     output logic rda_s);
    @(negedge clk);
    brg_en = en; rx_sample = lv; rd_ack = ack;
    @(posedge clk);
    if (evt == EV_COMMIT) begin
      e_busy = 1'b0;
      if (!e_rda || ack) begin
        e_data = cur_byte; e_rda = 1'b1; e_fe = ~lv; e_ovr = 1'b0;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (ack) begin
      e_rda = 1'b0; e_fe = 1'b0; e_ovr = 1'b0;
    end
    if (evt == EV_START) e_busy = 1'b1;
    if (evt == EV_ABORT) e_busy = 1'b0;
    #2 rda_s = rda;
  endtask

  // One brg tick = 5 clocks, brg_en on the first. ack_pos selects a clock (0..4).
  task automatic tick(input logic lv, input int ack_pos, input int evt, output logic rda_s);
    logic d, r, a;
    int   ev;
    ev = evt;
    r  = 1'b0;
    if (ev == EV_NONE && pend_abort == gt) begin
      ev = EV_ABORT;
      pend_abort = -1;
    end
    for (int c = 0; c < 5; c++) begin
      a = (c == ack_pos) || ($urandom_range(0, 999) < ack_pm);
      cyc(c == 0, lv, a, (c == 0) ? ev : EV_NONE, d);
      if (c == 0) r = d;
    end
    rda_s = r;
    gt++;
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) tick(1'b1, -1, EV_NONE, d);
  endtask

  task automatic ack_tick();
    logic d;
    tick(1'b1, 2, EV_NONE, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; brg_en = 1'b0; rd_ack = 1'b0; rx_sample = 1'b1;
    e_data = 8'h00; e_rda = 1'b0; e_fe = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    pend_abort = -1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rda",     32'(rda),     32'h0);
    check("rst_fe",      32'(frame_err), 32'h0);
    check("rst_ovr",     32'(overrun), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // 160-tick frame: start 0..15, data bit k at 16+16k.., stop 144..159.
  // ack_idx: tick whose brg clock carries rd_ack; rst_idx: tick where reset hits.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_idx,
                            input int rst_idx, output int rise_idx);
    logic rs, prev, lv;
    int   evt;
    rise_idx = -1;
    prev     = rda;
    cur_byte = b;
    for (int i = 0; i < 160; i++) begin
      if (i < 16)       lv = 1'b0;
      else if (i < 144) lv = b[(i - 16) / 16];
      else              lv = stop;
      evt = EV_NONE;
      if (i == 0)          evt = EV_START;
      if (i == COMMIT_IDX) evt = EV_COMMIT;
      // A low stop bit is seen again right after commit: a new start attempt
      // that fails 8 ticks later on the idle-high line.
      if (i == COMMIT_IDX + 1 && !stop) begin
        evt = EV_START;
        pend_abort = gt + 8;
      end
      if (i == rst_idx) begin
        do_reset();
        return;
      end
      tick(lv, (i == ack_idx) ? 0 : -1, evt, rs);
      if (rs && !prev && rise_idx < 0) rise_idx = i;
      prev = rs;
    end
  endtask

  task automatic glitch(input int len);
    logic d;
    for (int i = 0; i < 9; i++)
      tick((i < len) ? 1'b0 : 1'b1, -1,
           (i == 0) ? EV_START : (i == 8) ? EV_ABORT : EV_NONE, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ri;
    int         r;
    logic [7:0] bb [3];
    bb[0] = 8'h01; bb[1] = 8'h80; bb[2] = 8'hFF;

    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("init_rda",  32'(rda),     32'h0);
    check("init_data", 32'(rx_data), 32'h0);
    check("init_busy", 32'(busy),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Clean 0xA5.
    send_frame(8'hA5, 1'b1, -1, -1, ri);
    check("a5_latency", 32'(ri), 32'd152);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_rda",  32'(rda), 32'h1);
    check("a5_fe",   32'(frame_err), 32'h0);
    check("a5_ovr",  32'(overrun), 32'h0);
    ack_tick();
    check("a5_ack_rda",  32'(rda), 32'h0);
    check("a5_ack_hold", 32'(rx_data), 32'hA5);
    idle(2);

    // Glitch: 3 ticks low.
    glitch(3);
    idle(2);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_rda",  32'(rda),  32'h0);

    // Framing error on 0x3C, then clean 0x00 after an ack.
    send_frame(8'h3C, 1'b0, -1, -1, ri);
    idle(6);
    check("fe_data", 32'(rx_data), 32'h3C);
    check("fe_rda",  32'(rda), 32'h1);
    check("fe_flag", 32'(frame_err), 32'h1);
    ack_tick();
    send_frame(8'h00, 1'b1, -1, -1, ri);
    check("fe_clr_data", 32'(rx_data), 32'h00);
    check("fe_clr_flag", 32'(frame_err), 32'h0);
    ack_tick();

    // Overrun, then ack exactly on the second commit.
    send_frame(8'h11, 1'b1, -1, -1, ri);
    idle(4);
    send_frame(8'h22, 1'b1, -1, -1, ri);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_rda",  32'(rda), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    ack_tick();
    send_frame(8'h11, 1'b1, -1, -1, ri);
    idle(4);
    send_frame(8'h22, 1'b1, COMMIT_IDX, -1, ri);
    check("ackc_data", 32'(rx_data), 32'h22);
    check("ackc_rda",  32'(rda), 32'h1);
    check("ackc_ovr",  32'(overrun), 32'h0);
    ack_tick();

    // Reset in bit 4 of 0xFF, then 0x5A.
    send_frame(8'hFF, 1'b1, -1, 16 + 4 * 16 + 5, ri);
    idle(4);
    send_frame(8'h5A, 1'b1, -1, -1, ri);
    check("postrst_data", 32'(rx_data), 32'h5A);
    check("postrst_rda",  32'(rda), 32'h1);
    ack_tick();
    idle(2);

    // Back-to-back frames, single stop bit, ack after each commit.
    for (int k = 0; k < 3; k++) begin
      send_frame(bb[k], 1'b1, COMMIT_IDX + 3, -1, ri);
      check("b2b_latency", 32'(ri), 32'd152);
      check("b2b_data", 32'(rx_data), 32'(bb[k]));
      check("b2b_fe",   32'(frame_err), 32'h0);
      check("b2b_ovr",  32'(overrun), 32'h0);
    end
    idle(4);

    // Randomized traffic with sporadic acks.
    ack_pm = 3;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) glitch(int'($urandom_range(1, 7)));
      else send_frame(8'($urandom), (r == 1) ? 1'b0 : 1'b1,
                      ($urandom_range(0, 3) == 0) ? COMMIT_IDX : -1, -1, ri);
      idle(int'($urandom_range(4, 12)));
    end
    ack_pm = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
